// File: rtl/mb_boundary_ctx.sv
// mb_boundary_ctx: VP8 intra neighbour-context engine (top, top-right, left, top-left).
// Optional macro TOP_RIGHT_EN enables the x+1 top-right read and the WT state.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   MB reconstruction + coordinates handshake
//   x, y, mb_w            MB column, MB row, MBs per row (mb_w >= 1)
//   y_rec, u_rec, v_rec   reconstructed planes, raster order, pixel 0 in LSBs
//   out_valid / out_ready context handshake
//   top_y                 top row, upper 4 pixels are top-right
//   top_u, top_v          chroma top rows
//   left_y/u/v            left columns, row 0 in LSBs
//   top_left_y/u/v        corner pixels
module mb_boundary_ctx #(
    parameter int PIX_W    = 8,
    parameter int LUMA_N   = 16,
    parameter int CHROMA_N = 8,
    parameter int ADDR_W   = 10
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [ADDR_W-1:0]                   x,
    input  logic [ADDR_W-1:0]                   y,
    input  logic [ADDR_W-1:0]                   mb_w,
    input  logic [PIX_W*LUMA_N*LUMA_N-1:0]      y_rec,
    input  logic [PIX_W*CHROMA_N*CHROMA_N-1:0]  u_rec,
    input  logic [PIX_W*CHROMA_N*CHROMA_N-1:0]  v_rec,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [PIX_W*(LUMA_N+4)-1:0]         top_y,
    output logic [PIX_W*CHROMA_N-1:0]           top_u,
    output logic [PIX_W*CHROMA_N-1:0]           top_v,
    output logic [PIX_W*LUMA_N-1:0]             left_y,
    output logic [PIX_W*CHROMA_N-1:0]           left_u,
    output logic [PIX_W*CHROMA_N-1:0]           left_v,
    output logic [PIX_W-1:0]                    top_left_y,
    output logic [PIX_W-1:0]                    top_left_u,
    output logic [PIX_W-1:0]                    top_left_v
);

    localparam int YB  = PIX_W*LUMA_N*LUMA_N;
    localparam int CB  = PIX_W*CHROMA_N*CHROMA_N;
    localparam int LW  = PIX_W*LUMA_N;
    localparam int CW  = PIX_W*CHROMA_N;
    localparam int MW  = LW + 2*CW;
    localparam int TRW = 4*PIX_W;

    localparam logic [PIX_W-1:0] P127 = PIX_W'(127);
    localparam logic [PIX_W-1:0] P129 = PIX_W'(129);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WT,
        S_CAP,
        S_WR,
        S_OUT
    } state_t;

    state_t state;
    state_t nxt;

    logic accept;
    assign accept = in_valid && in_ready;

    // Out-of-range columns are folded onto the last column of the row.
    logic [ADDR_W-1:0] x_cl;
    always_comb begin
        x_cl = x;
        if (mb_w == '0) begin
            x_cl = '0;
        end else if (x >= mb_w) begin
            x_cl = mb_w - ADDR_W'(1);
        end
    end

    // Only the bottom row and right column of each plane are ever needed.
    logic [LW-1:0] col_y_in;
    logic [CW-1:0] col_u_in;
    logic [CW-1:0] col_v_in;
    always_comb begin
        col_y_in = '0;
        col_u_in = '0;
        col_v_in = '0;
        for (int r = 0; r < LUMA_N; r++) begin
            col_y_in[r*PIX_W +: PIX_W] =
                y_rec[(r*LUMA_N + LUMA_N-1)*PIX_W +: PIX_W];
        end
        for (int r = 0; r < CHROMA_N; r++) begin
            col_u_in[r*PIX_W +: PIX_W] =
                u_rec[(r*CHROMA_N + CHROMA_N-1)*PIX_W +: PIX_W];
            col_v_in[r*PIX_W +: PIX_W] =
                v_rec[(r*CHROMA_N + CHROMA_N-1)*PIX_W +: PIX_W];
        end
    end

    logic unused_rec;
    assign unused_rec = ^{y_rec, u_rec, v_rec};

    logic [ADDR_W-1:0] x_q;
    logic              y0_q;
    logic [LW-1:0]     bot_y_q;
    logic [CW-1:0]     bot_u_q;
    logic [CW-1:0]     bot_v_q;
    logic [LW-1:0]     col_y_q;
    logic [CW-1:0]     col_u_q;
    logic [CW-1:0]     col_v_q;

`ifdef TOP_RIGHT_EN
    logic [ADDR_W:0]   x_inc;
    logic [ADDR_W-1:0] x1_q;
    logic              last_q;
    assign x_inc = {1'b0, x_cl} + (ADDR_W+1)'(1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y0_q    <= 1'b1;
            bot_y_q <= '0;
            bot_u_q <= '0;
            bot_v_q <= '0;
            col_y_q <= '0;
            col_u_q <= '0;
            col_v_q <= '0;
`ifdef TOP_RIGHT_EN
            x1_q    <= '0;
            last_q  <= 1'b1;
`endif
        end else if (accept) begin
            x_q     <= x_cl;
            y0_q    <= (y == '0);
            bot_y_q <= y_rec[YB-1 -: LW];
            bot_u_q <= u_rec[CB-1 -: CW];
            bot_v_q <= v_rec[CB-1 -: CW];
            col_y_q <= col_y_in;
            col_u_q <= col_u_in;
            col_v_q <= col_v_in;
`ifdef TOP_RIGHT_EN
            // x+1 never wraps: at the last column the read is skipped.
            x1_q    <= x_inc[ADDR_W-1:0];
            last_q  <= (x_inc >= {1'b0, mb_w});
`endif
        end
    end

    // Line buffer word: {v row, u row, y row}, luma pixel 0 in LSBs.
    logic [MW-1:0] mem [2**ADDR_W];
    logic [MW-1:0] rd_a;
    logic [MW-1:0] wr_word;

    assign wr_word = {bot_v_q, bot_u_q, bot_y_q};

    always_ff @(posedge clk) begin
        if (state == S_RD) begin
            rd_a <= mem[x_q];
        end
        if (state == S_WR) begin
            mem[x_q] <= wr_word;
        end
    end

    logic [LW-1:0]  buf_y;
    logic [CW-1:0]  buf_u;
    logic [CW-1:0]  buf_v;
    logic [TRW-1:0] tr;

    assign buf_y = rd_a[LW-1:0];
    assign buf_u = rd_a[LW +: CW];
    assign buf_v = rd_a[LW+CW +: CW];

`ifdef TOP_RIGHT_EN
    logic [TRW-1:0] rd_b;

    always_ff @(posedge clk) begin
        if (state == S_RD && !last_q) begin
            rd_b <= mem[x1_q][TRW-1:0];
        end
    end

    assign tr = last_q ? {4{buf_y[LW-1 -: PIX_W]}} : rd_b;
`else
    assign tr = {4{P127}};
`endif

    logic x0;
    assign x0 = (x_q == '0);

    logic [LW-1:0]    left_y_q;
    logic [CW-1:0]    left_u_q;
    logic [CW-1:0]    left_v_q;
    logic [PIX_W-1:0] tl_y_q;
    logic [PIX_W-1:0] tl_u_q;
    logic [PIX_W-1:0] tl_v_q;
    logic [PIX_W-1:0] ntl_y;
    logic [PIX_W-1:0] ntl_u;
    logic [PIX_W-1:0] ntl_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_y      <= '0;
            top_u      <= '0;
            top_v      <= '0;
            left_y     <= '0;
            left_u     <= '0;
            left_v     <= '0;
            top_left_y <= '0;
            top_left_u <= '0;
            top_left_v <= '0;
            left_y_q   <= '0;
            left_u_q   <= '0;
            left_v_q   <= '0;
            tl_y_q     <= '0;
            tl_u_q     <= '0;
            tl_v_q     <= '0;
            ntl_y      <= '0;
            ntl_u      <= '0;
            ntl_v      <= '0;
        end else begin
            if (state == S_CAP) begin
                top_y  <= y0_q ? {(LUMA_N+4){P127}} : {tr, buf_y};
                top_u  <= y0_q ? {CHROMA_N{P127}} : buf_u;
                top_v  <= y0_q ? {CHROMA_N{P127}} : buf_v;
                left_y <= x0 ? {LUMA_N{P129}} : left_y_q;
                left_u <= x0 ? {CHROMA_N{P129}} : left_u_q;
                left_v <= x0 ? {CHROMA_N{P129}} : left_v_q;
                top_left_y <= y0_q ? P127 : (x0 ? P129 : tl_y_q);
                top_left_u <= y0_q ? P127 : (x0 ? P129 : tl_u_q);
                top_left_v <= y0_q ? P127 : (x0 ? P129 : tl_v_q);
                // Old top row's last pixel is the next MB's corner.
                ntl_y <= buf_y[LW-1 -: PIX_W];
                ntl_u <= buf_u[CW-1 -: PIX_W];
                ntl_v <= buf_v[CW-1 -: PIX_W];
            end
            if (state == S_WR) begin
                left_y_q <= col_y_q;
                left_u_q <= col_u_q;
                left_v_q <= col_v_q;
                tl_y_q   <= ntl_y;
                tl_u_q   <= ntl_u;
                tl_v_q   <= ntl_v;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: if (accept) nxt = S_RD;
`ifdef TOP_RIGHT_EN
            S_RD:   nxt = S_WT;
`else
            S_RD:   nxt = S_CAP;
`endif
            S_WT:   nxt = S_CAP;
            S_CAP:  nxt = S_WR;
            S_WR:   nxt = S_OUT;
            S_OUT:  if (out_ready) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_OUT);
    end

endmodule

// File: tb/tb_mb_boundary_ctx.sv
// tb_mb_boundary_ctx: random frames checked against a frame-level context model.
// Works with or without TOP_RIGHT_EN defined.
module tb_mb_boundary_ctx;

    localparam int PW = 8;
    localparam int LN = 16;
    localparam int CN = 8;
    localparam int AW = 10;
`ifdef TOP_RIGHT_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [AW-1:0]         x = '0;
    logic [AW-1:0]         y = '0;
    logic [AW-1:0]         mb_w = '0;
    logic [PW*LN*LN-1:0]   y_rec = '0;
    logic [PW*CN*CN-1:0]   u_rec = '0;
    logic [PW*CN*CN-1:0]   v_rec = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [PW*(LN+4)-1:0]  top_y;
    logic [PW*CN-1:0]      top_u;
    logic [PW*CN-1:0]      top_v;
    logic [PW*LN-1:0]      left_y;
    logic [PW*CN-1:0]      left_u;
    logic [PW*CN-1:0]      left_v;
    logic [PW-1:0]         top_left_y;
    logic [PW-1:0]         top_left_u;
    logic [PW-1:0]         top_left_v;

    always #5 clk = ~clk;

    mb_boundary_ctx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .y          (y),
        .mb_w       (mb_w),
        .y_rec      (y_rec),
        .u_rec      (u_rec),
        .v_rec      (v_rec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .top_y      (top_y),
        .top_u      (top_u),
        .top_v      (top_v),
        .left_y     (left_y),
        .left_u     (left_u),
        .left_v     (left_v),
        .top_left_y (top_left_y),
        .top_left_u (top_left_u),
        .top_left_v (top_left_v)
    );

    // Reconstructed picture: the model reads neighbours straight from it.
    logic [7:0] fy [0:47][0:95];
    logic [7:0] fu [0:23][0:47];
    logic [7:0] fv [0:23][0:47];

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [159:0] got,
                         input logic [159:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic fill_mb(input int mx, input int my, input bit rnd,
                           input logic [7:0] val);
        for (int r = 0; r < LN; r++)
            for (int c = 0; c < LN; c++)
                fy[LN*my+r][LN*mx+c] = rnd ? 8'($urandom) : val;
        for (int r = 0; r < CN; r++)
            for (int c = 0; c < CN; c++) begin
                fu[CN*my+r][CN*mx+c] = rnd ? 8'($urandom) : val;
                fv[CN*my+r][CN*mx+c] = rnd ? 8'($urandom) : val;
            end
    endtask

    task automatic pack_mb(input int mx, input int my);
        for (int r = 0; r < LN; r++)
            for (int c = 0; c < LN; c++)
                y_rec[(r*LN+c)*PW +: PW] = fy[LN*my+r][LN*mx+c];
        for (int r = 0; r < CN; r++)
            for (int c = 0; c < CN; c++) begin
                u_rec[(r*CN+c)*PW +: PW] = fu[CN*my+r][CN*mx+c];
                v_rec[(r*CN+c)*PW +: PW] = fv[CN*my+r][CN*mx+c];
            end
    endtask

    task automatic scramble();
        x = AW'($urandom);
        y = AW'($urandom);
        mb_w = AW'($urandom);
        for (int i = 0; i < PW*LN*LN/32; i++) y_rec[i*32 +: 32] = $urandom;
        for (int i = 0; i < PW*CN*CN/32; i++) begin
            u_rec[i*32 +: 32] = $urandom;
            v_rec[i*32 +: 32] = $urandom;
        end
    endtask

    task automatic model(input int mx, input int my, input int mbw,
                         output logic [159:0] ty, output logic [63:0] tu,
                         output logic [63:0] tv, output logic [127:0] ly,
                         output logic [63:0] lu, output logic [63:0] lv,
                         output logic [7:0] tly, output logic [7:0] tlu,
                         output logic [7:0] tlv);
        int ry;
        int rc;
        ry = LN*my - 1;
        rc = CN*my - 1;
        ty = '0; tu = '0; tv = '0; ly = '0; lu = '0; lv = '0;
        if (my == 0) begin
            ty = {20{8'd127}};
            tu = {8{8'd127}};
            tv = {8{8'd127}};
            tly = 8'd127; tlu = 8'd127; tlv = 8'd127;
        end else begin
            for (int c = 0; c < LN; c++) ty[c*8 +: 8] = fy[ry][LN*mx+c];
            for (int k = 0; k < 4; k++) begin
`ifdef TOP_RIGHT_EN
                if (mx < mbw-1) ty[(LN+k)*8 +: 8] = fy[ry][LN*mx+LN+k];
                else            ty[(LN+k)*8 +: 8] = fy[ry][LN*mx+LN-1];
`else
                ty[(LN+k)*8 +: 8] = 8'd127;
`endif
            end
            for (int c = 0; c < CN; c++) begin
                tu[c*8 +: 8] = fu[rc][CN*mx+c];
                tv[c*8 +: 8] = fv[rc][CN*mx+c];
            end
            if (mx == 0) begin
                tly = 8'd129; tlu = 8'd129; tlv = 8'd129;
            end else begin
                tly = fy[ry][LN*mx-1];
                tlu = fu[rc][CN*mx-1];
                tlv = fv[rc][CN*mx-1];
            end
        end
        if (mx == 0) begin
            ly = {16{8'd129}};
            lu = {8{8'd129}};
            lv = {8{8'd129}};
        end else begin
            for (int r = 0; r < LN; r++) ly[r*8 +: 8] = fy[LN*my+r][LN*mx-1];
            for (int r = 0; r < CN; r++) begin
                lu[r*8 +: 8] = fu[CN*my+r][CN*mx-1];
                lv[r*8 +: 8] = fv[CN*my+r][CN*mx-1];
            end
        end
    endtask

    task automatic run_mb(input int mx, input int my, input int mbw,
                          input bit stall);
        logic [159:0] e_ty;
        logic [63:0]  e_tu, e_tv, e_lu, e_lv;
        logic [127:0] e_ly;
        logic [7:0]   e_tly, e_tlu, e_tlv;
        int lat;
        bit seen;
        model(mx, my, mbw, e_ty, e_tu, e_tv, e_ly, e_lu, e_lv,
              e_tly, e_tlu, e_tlv);
        @(negedge clk);
        x = AW'(mx);
        y = AW'(my);
        mb_w = AW'(mbw);
        pack_mb(mx, my);
        in_valid = 1'b1;
        check("idle_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble();
        lat = 0;
        seen = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (!seen) begin
                @(negedge clk);
                if (out_valid) begin
                    seen = 1'b1;
                    lat = k;
                end
            end
        end
        if (!seen) begin
            check("out_valid_timeout", 0, 1);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
        end
        check("latency", lat, LAT);
        check("top_y", top_y, e_ty);
        check("top_u", top_u, e_tu);
        check("top_v", top_v, e_tv);
        check("left_y", left_y, e_ly);
        check("left_u", left_u, e_lu);
        check("left_v", left_v, e_lv);
        check("top_left_y", top_left_y, e_tly);
        check("top_left_u", top_left_u, e_tlu);
        check("top_left_v", top_left_v, e_tlv);
        if (stall) begin
            in_valid = 1'b1;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                check("stall_out_valid", out_valid, 1);
                check("stall_in_ready", in_ready, 0);
                check("stall_top_y", top_y, e_ty);
                check("stall_left_y", left_y, e_ly);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("ret_in_ready", in_ready, 1);
        check("ret_out_valid", out_valid, 0);
    endtask

    task automatic run_frame(input int mbw, input int rows, input bit dir,
                             input int st_x, input int st_y);
        for (int my = 0; my < rows; my++)
            for (int mx = 0; mx < mbw; mx++) begin
                if (dir && my == 0) begin
                    fill_mb(mx, my, 1'b0, 8'(8'h10 * (mx + 1)));
                    if (mx == 3) fy[LN-1][LN*3+LN-1] = 8'h5A;
                end else begin
                    fill_mb(mx, my, 1'b1, 8'h00);
                end
                run_mb(mx, my, mbw, (mx == st_x) && (my == st_y));
            end
    endtask

    task automatic abort_mid_wt();
        @(negedge clk);
        x = AW'(2);
        y = AW'(1);
        mb_w = AW'(4);
        scramble();
        x = AW'(2);
        y = AW'(1);
        mb_w = AW'(4);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_top_y", top_y, 0);
        check("abort_left_y", left_y, 0);
        check("abort_top_left_y", top_left_y, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int mbw;
        int rows;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_top_y", top_y, 0);
        check("rst_left_y", left_y, 0);
        check("rst_top_left_y", top_left_y, 0);
        rst_n = 1'b1;

        run_frame(4, 2, 1'b1, 1, 1);

        for (int f = 0; f < 5; f++) begin
            mbw = $urandom_range(1, 6);
            rows = $urandom_range(2, 3);
            run_frame(mbw, rows, 1'b0,
                      $urandom_range(0, mbw-1), $urandom_range(0, rows-1));
        end

        abort_mid_wt();
        run_frame(3, 2, 1'b0, 7, 7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
